// File: rtl/prog_sequencer_if.sv
// Bus between the run-control sequencer and its environment: start/branch
// decode inputs toward the sequencer, PC controls and status back out.
interface prog_sequencer_if #(
    parameter int unsigned L  = 10,
    parameter int unsigned CW = 16
);
    // request and decoded-instruction side
    logic          Req;
    logic [1:0]    ProgSel;
    logic          Halt;
    logic          BrEn;
    logic          BrAbs;
    logic          BrCond;
    logic          Flag;
    logic [L-1:0]  BrTarget;

    // PC control and status side
    logic          PcReset;
    logic          PcStart;
    logic          PcBranchAbs;
    logic          PcBranchRel;
    logic [L-1:0]  PcTarget;
    logic          Busy;
    logic          Done;
    logic          Timeout;
    logic [CW-1:0] CycleCount;

    // environment / top level drives requests and decode, observes controls
    modport master (
        output Req, ProgSel, Halt, BrEn, BrAbs, BrCond, Flag, BrTarget,
        input  PcReset, PcStart, PcBranchAbs, PcBranchRel, PcTarget,
               Busy, Done, Timeout, CycleCount
    );

    // sequencer side
    modport slave (
        input  Req, ProgSel, Halt, BrEn, BrAbs, BrCond, Flag, BrTarget,
        output PcReset, PcStart, PcBranchAbs, PcBranchRel, PcTarget,
               Busy, Done, Timeout, CycleCount
    );
endinterface

// File: rtl/prog_sequencer.sv
// Run-control and branch-resolution controller for the program counter.
// Loads a program base address on request, converts decoded branch/halt
// information into PC controls with zero added latency, counts run cycles
// and stops a runaway program with a watchdog.
module prog_sequencer #(
    parameter int unsigned L       = 10,
    parameter int unsigned CW      = 16,
    parameter int unsigned P1_BASE = 0,
    parameter int unsigned P2_BASE = 128,
    parameter int unsigned P3_BASE = 256,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic          Clk,
    input  logic          Reset,
    prog_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0]    SEL_INVALID = 2'd3;
    localparam logic [CW-1:0] WDOG_LIMIT  = CW'(TIMEOUT);
    localparam logic [CW-1:0] COUNT_MAX   = '1;

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    sel_q;
    logic [CW-1:0] count_q;
    logic          timeout_q;

    logic [L-1:0]  base_addr;
    logic          branch_taken;
    logic          wdog_hit;

    logic          latch_sel;
    logic          clear_run;
    logic          inc_count;
    logic          set_timeout;
    logic          pc_start;
    logic          pc_branch_abs;
    logic          pc_branch_rel;
    logic [L-1:0]  pc_target;

    // Base address of the latched program
    always_comb begin
        case (sel_q)
            2'd0:    base_addr = L'(P1_BASE);
            2'd1:    base_addr = L'(P2_BASE);
            default: base_addr = L'(P3_BASE);
        endcase
    end

    assign branch_taken = bus.BrEn & (~bus.BrCond | bus.Flag);
    assign wdog_hit     = (count_q == WDOG_LIMIT);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and PC control decode; PC holds unless explicitly released
    always_comb begin
        state_d       = state_q;
        pc_start      = 1'b1;
        pc_branch_abs = 1'b0;
        pc_branch_rel = 1'b0;
        pc_target     = '0;
        latch_sel     = 1'b0;
        clear_run     = 1'b0;
        inc_count     = 1'b0;
        set_timeout   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Req && (bus.ProgSel != SEL_INVALID)) begin
                    latch_sel = 1'b1;
                    state_d   = LOAD;
                end
            end

            LOAD: begin
                pc_start      = 1'b0;
                pc_branch_abs = 1'b1;
                pc_target     = base_addr;
                clear_run     = 1'b1;
                state_d       = RUN;
            end

            RUN: begin
                if (bus.Halt) begin
                    // a halt on the watchdog cycle still records the timeout
                    set_timeout = wdog_hit;
                    state_d     = DONE;
                end else if (wdog_hit) begin
                    set_timeout = 1'b1;
                    state_d     = DONE;
                end else begin
                    pc_start  = 1'b0;
                    inc_count = 1'b1;
                    if (branch_taken) begin
                        pc_branch_abs = bus.BrAbs;
                        pc_branch_rel = ~bus.BrAbs;
                        pc_target     = bus.BrTarget;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Program select latch, saturating run-cycle counter and sticky watchdog flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sel_q     <= 2'd0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (latch_sel) begin
                sel_q <= bus.ProgSel;
            end
            if (clear_run) begin
                count_q   <= '0;
                timeout_q <= 1'b0;
            end else begin
                if (inc_count && (count_q != COUNT_MAX)) begin
                    count_q <= count_q + CW'(1);
                end
                if (set_timeout) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    // The PC clears on the same edge as the sequencer
    assign bus.PcReset     = Reset;
    assign bus.PcStart     = pc_start;
    assign bus.PcBranchAbs = pc_branch_abs;
    assign bus.PcBranchRel = pc_branch_rel;
    assign bus.PcTarget    = pc_target;
    assign bus.Busy        = (state_q == LOAD) || (state_q == RUN);
    assign bus.Done        = (state_q == DONE);
    assign bus.Timeout     = timeout_q;
    assign bus.CycleCount  = count_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: a small PC register driven by the DUT's
// controls, one task per scenario, inputs driven and outputs sampled on the
// falling edge.
module tb_prog_sequencer;

    localparam int unsigned L  = 10;
    localparam int unsigned CW = 16;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    prog_sequencer_if #(.L(L), .CW(CW)) bus ();

    prog_sequencer #(
        .L(L), .CW(CW),
        .P1_BASE(0), .P2_BASE(128), .P3_BASE(256),
        .TIMEOUT(8)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    // external PC register steered by the sequencer
    logic [L-1:0] pc;
    always @(posedge Clk) begin
        if (bus.PcReset)          pc <= '0;
        else if (bus.PcBranchAbs) pc <= bus.PcTarget;
        else if (bus.PcBranchRel) pc <= pc + bus.PcTarget;
        else if (!bus.PcStart)    pc <= pc + 10'd1;
    end

    int checks   = 0;
    int failures = 0;
    int done_pulses = 0;
    int base_pulses;

    always @(negedge Clk) begin
        if (bus.Done === 1'b1) done_pulses++;
    end

    task automatic clear_inputs();
        bus.Req = 1'b0; bus.ProgSel = 2'd0; bus.Halt = 1'b0; bus.BrEn = 1'b0;
        bus.BrAbs = 1'b0; bus.BrCond = 1'b0; bus.Flag = 1'b0; bus.BrTarget = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        clear_inputs();
        @(negedge Clk);
        #1;
        checks++; if (bus.PcReset !== 1'b1) begin failures++; $display("FAIL reset_pcreset: got %b want 1", bus.PcReset); end
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.PcStart !== 1'b1) begin failures++; $display("FAIL reset_pcstart[%0d]: got %b want 1", i, bus.PcStart); end
            checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b want 0", i, bus.Busy); end
            checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL reset_done[%0d]: got %b want 0", i, bus.Done); end
            checks++; if (bus.Timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout[%0d]: got %b want 0", i, bus.Timeout); end
            checks++; if (bus.CycleCount !== 16'd0) begin failures++; $display("FAIL reset_count[%0d]: got %0d want 0", i, bus.CycleCount); end
            checks++; if (bus.PcBranchAbs !== 1'b0 || bus.PcBranchRel !== 1'b0 || bus.PcTarget !== 10'd0) begin failures++; $display("FAIL reset_branch[%0d]: got abs=%b rel=%b tgt=%0d want 0/0/0", i, bus.PcBranchAbs, bus.PcBranchRel, bus.PcTarget); end
            checks++; if (pc !== 10'd0) begin failures++; $display("FAIL reset_pc[%0d]: got %0d want 0", i, pc); end
            @(negedge Clk);
        end
    endtask

    task automatic test_program();
        base_pulses = done_pulses;
        bus.Req = 1'b1; bus.ProgSel = 2'd1;
        #1;
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL prog_idle_busy: got %b want 0", bus.Busy); end
        @(negedge Clk);
        bus.Req = 1'b0; bus.ProgSel = 2'd0;
        #1;
        checks++; if (bus.PcBranchAbs !== 1'b1) begin failures++; $display("FAIL prog_load_abs: got %b want 1", bus.PcBranchAbs); end
        checks++; if (bus.PcTarget !== 10'd128) begin failures++; $display("FAIL prog_load_target: got %0d want 128", bus.PcTarget); end
        checks++; if (bus.PcStart !== 1'b0 || bus.Busy !== 1'b1) begin failures++; $display("FAIL prog_load_ctl: got start=%b busy=%b want 0/1", bus.PcStart, bus.Busy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            bus.Halt = (pc == 10'd130);
            #1;
            checks++; if (pc !== 10'(128 + i)) begin failures++; $display("FAIL prog_run_pc[%0d]: got %0d want %0d", i, pc, 128 + i); end
            checks++; if (bus.PcStart !== (i == 2)) begin failures++; $display("FAIL prog_run_start[%0d]: got %b want %b", i, bus.PcStart, (i == 2)); end
        end
        @(negedge Clk);
        bus.Halt = 1'b0;
        #1;
        checks++; if (bus.Done !== 1'b1) begin failures++; $display("FAIL prog_done: got %b want 1", bus.Done); end
        checks++; if (bus.CycleCount !== 16'd2) begin failures++; $display("FAIL prog_count: got %0d want 2", bus.CycleCount); end
        checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL prog_done_busy: got %b want 0", bus.Busy); end
        checks++; if (pc !== 10'd130) begin failures++; $display("FAIL prog_done_pc: got %0d want 130", pc); end
        @(negedge Clk);
        #1;
        checks++; if (bus.Done !== 1'b0) begin failures++; $display("FAIL prog_done_width: got %b want 0", bus.Done); end
        checks++; if (pc !== 10'd130) begin failures++; $display("FAIL prog_hold_pc: got %0d want 130", pc); end
        checks++; if (done_pulses - base_pulses !== 1) begin failures++; $display("FAIL prog_pulse_count: got %0d want 1", done_pulses - base_pulses); end
    endtask

    task automatic test_branch();
        bus.Req = 1'b1; bus.ProgSel = 2'd0;
        @(negedge Clk);
        bus.Req = 1'b0;
        #1;
        checks++; if (bus.PcBranchAbs !== 1'b1 || bus.PcTarget !== 10'd0) begin failures++; $display("FAIL br_load: got abs=%b tgt=%0d want 1/0", bus.PcBranchAbs, bus.PcTarget); end
        @(negedge Clk);
        bus.BrEn = 1'b1; bus.BrCond = 1'b1; bus.BrAbs = 1'b0; bus.BrTarget = 10'h3FD; bus.Flag = 1'b0;
        #1;
        checks++; if (pc !== 10'd0) begin failures++; $display("FAIL br_pc0: got %0d want 0", pc); end
        checks++; if (bus.PcBranchRel !== 1'b0 || bus.PcBranchAbs !== 1'b0 || bus.PcStart !== 1'b0) begin failures++; $display("FAIL br_nottaken: got rel=%b abs=%b start=%b want 0/0/0", bus.PcBranchRel, bus.PcBranchAbs, bus.PcStart); end
        @(negedge Clk);
        bus.Flag = 1'b1;
        #1;
        checks++; if (pc !== 10'd1) begin failures++; $display("FAIL br_pc1: got %0d want 1", pc); end
        checks++; if (bus.PcBranchRel !== 1'b1 || bus.PcBranchAbs !== 1'b0 || bus.PcTarget !== 10'h3FD) begin failures++; $display("FAIL br_rel: got rel=%b abs=%b tgt=%h want 1/0/3fd", bus.PcBranchRel, bus.PcBranchAbs, bus.PcTarget); end
        @(negedge Clk);
        bus.BrAbs = 1'b1; bus.BrCond = 1'b0; bus.Flag = 1'b0; bus.BrTarget = 10'd5;
        #1;
        checks++; if (pc !== 10'h3FE) begin failures++; $display("FAIL br_pc_rel_wrap: got %h want 3fe", pc); end
        checks++; if (bus.PcBranchAbs !== 1'b1 || bus.PcBranchRel !== 1'b0 || bus.PcTarget !== 10'd5) begin failures++; $display("FAIL br_abs: got abs=%b rel=%b tgt=%0d want 1/0/5", bus.PcBranchAbs, bus.PcBranchRel, bus.PcTarget); end
        @(negedge Clk);
        bus.BrEn = 1'b0; bus.BrAbs = 1'b0; bus.BrTarget = '0; bus.Halt = 1'b1;
        #1;
        checks++; if (pc !== 10'd5) begin failures++; $display("FAIL br_pc_abs: got %0d want 5", pc); end
        @(negedge Clk);
        bus.Halt = 1'b0;
        #1;
        checks++; if (bus.Done !== 1'b1 || bus.CycleCount !== 16'd3) begin failures++; $display("FAIL br_done: got done=%b count=%0d want 1/3", bus.Done, bus.CycleCount); end
        @(negedge Clk);
    endtask

    task automatic test_invalid_and_done_req();
        bus.Req = 1'b1; bus.ProgSel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.Busy !== 1'b0 || bus.PcBranchAbs !== 1'b0 || bus.PcStart !== 1'b1) begin failures++; $display("FAIL inv_sel[%0d]: got busy=%b abs=%b start=%b want 0/0/1", i, bus.Busy, bus.PcBranchAbs, bus.PcStart); end
            @(negedge Clk);
        end
        #1;
        checks++; if (pc !== 10'd5) begin failures++; $display("FAIL inv_pc: got %0d want 5", pc); end
        bus.ProgSel = 2'd2;
        @(negedge Clk);
        bus.Req = 1'b0; bus.ProgSel = 2'd0;
        #1;
        checks++; if (bus.PcTarget !== 10'd256 || bus.PcBranchAbs !== 1'b1) begin failures++; $display("FAIL p3_load: got tgt=%0d abs=%b want 256/1", bus.PcTarget, bus.PcBranchAbs); end
        @(negedge Clk);
        bus.Halt = 1'b1;
        @(negedge Clk);
        bus.Halt = 1'b0; bus.Req = 1'b1; bus.ProgSel = 2'd1;
        #1;
        checks++; if (bus.Done !== 1'b1 || bus.CycleCount !== 16'd0) begin failures++; $display("FAIL p3_done: got done=%b count=%0d want 1/0", bus.Done, bus.CycleCount); end
        @(negedge Clk);
        bus.Req = 1'b0; bus.ProgSel = 2'd0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.Busy !== 1'b0 || bus.PcBranchAbs !== 1'b0 || bus.Done !== 1'b0) begin failures++; $display("FAIL done_req_ignored[%0d]: got busy=%b abs=%b done=%b want 0/0/0", i, bus.Busy, bus.PcBranchAbs, bus.Done); end
            checks++; if (pc !== 10'd256) begin failures++; $display("FAIL done_req_pc[%0d]: got %0d want 256", i, pc); end
            @(negedge Clk);
        end
    endtask

    task automatic test_timeout();
        bus.Req = 1'b1; bus.ProgSel = 2'd0;
        @(negedge Clk);
        bus.Req = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge Clk);
            #1;
            checks++; if (bus.CycleCount !== 16'(i) || pc !== 10'(i)) begin failures++; $display("FAIL wd_run[%0d]: got count=%0d pc=%0d want %0d/%0d", i, bus.CycleCount, pc, i, i); end
            checks++; if (bus.PcStart !== (i == 8)) begin failures++; $display("FAIL wd_start[%0d]: got %b want %b", i, bus.PcStart, (i == 8)); end
        end
        @(negedge Clk);
        #1;
        checks++; if (bus.Done !== 1'b1 || bus.Timeout !== 1'b1 || bus.CycleCount !== 16'd8) begin failures++; $display("FAIL wd_done: got done=%b to=%b count=%0d want 1/1/8", bus.Done, bus.Timeout, bus.CycleCount); end
        @(negedge Clk);
        bus.Req = 1'b1; bus.ProgSel = 2'd1;
        #1;
        checks++; if (bus.Timeout !== 1'b1 || bus.Done !== 1'b0) begin failures++; $display("FAIL wd_sticky: got to=%b done=%b want 1/0", bus.Timeout, bus.Done); end
        @(negedge Clk);
        bus.Req = 1'b0; bus.ProgSel = 2'd0;
        @(negedge Clk);
        #1;
        checks++; if (bus.Timeout !== 1'b0 || bus.CycleCount !== 16'd0 || pc !== 10'd128) begin failures++; $display("FAIL wd_cleared: got to=%b count=%0d pc=%0d want 0/0/128", bus.Timeout, bus.CycleCount, pc); end
        // halt arriving on the watchdog cycle: halts and still flags timeout
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clk);
            bus.Halt = (i == 8);
        end
        #1;
        checks++; if (bus.CycleCount !== 16'd8 || bus.PcStart !== 1'b1) begin failures++; $display("FAIL wd_halt_cycle: got count=%0d start=%b want 8/1", bus.CycleCount, bus.PcStart); end
        @(negedge Clk);
        bus.Halt = 1'b0;
        #1;
        checks++; if (bus.Done !== 1'b1 || bus.Timeout !== 1'b1 || bus.CycleCount !== 16'd8) begin failures++; $display("FAIL wd_halt_done: got done=%b to=%b count=%0d want 1/1/8", bus.Done, bus.Timeout, bus.CycleCount); end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid_run();
        bus.Req = 1'b1; bus.ProgSel = 2'd1;
        @(negedge Clk);
        bus.Req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        checks++; if (pc !== 10'd129) begin failures++; $display("FAIL mid_pre_pc: got %0d want 129", pc); end
        base_pulses = done_pulses;
        Reset = 1'b1;
        bus.BrEn = 1'b1; bus.BrAbs = 1'b1; bus.BrCond = 1'b0; bus.BrTarget = 10'd5;
        #1;
        checks++; if (bus.PcReset !== 1'b1) begin failures++; $display("FAIL mid_pcreset: got %b want 1", bus.PcReset); end
        @(negedge Clk);
        Reset = 1'b0;
        clear_inputs();
        #1;
        checks++; if (pc !== 10'd0) begin failures++; $display("FAIL mid_pc: got %0d want 0", pc); end
        checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.PcStart !== 1'b1) begin failures++; $display("FAIL mid_idle: got busy=%b done=%b start=%b want 0/0/1", bus.Busy, bus.Done, bus.PcStart); end
        checks++; if (bus.CycleCount !== 16'd0 || bus.Timeout !== 1'b0) begin failures++; $display("FAIL mid_count: got count=%0d to=%b want 0/0", bus.CycleCount, bus.Timeout); end
        @(negedge Clk);
        @(negedge Clk);
        #1;
        checks++; if (done_pulses - base_pulses !== 0) begin failures++; $display("FAIL mid_no_done: got %0d pulses want 0", done_pulses - base_pulses); end
        checks++; if (pc !== 10'd0 || bus.Busy !== 1'b0) begin failures++; $display("FAIL mid_stay_idle: got pc=%0d busy=%b want 0/0", pc, bus.Busy); end
    endtask

    initial begin
        test_reset();
        test_program();
        test_branch();
        test_invalid_and_done_req();
        test_timeout();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Run-control and branch-resolution controller for the program counter register. It accepts a start request with a program select and loads that program's base address into the PC. While the program runs, it turns decoded branch/halt information into the PC's Start/BranchAbs/BranchRel/Target controls. It counts run cycles, enforces a watchdog, and signals completion to the testbench/top level.

Parameters:
L, 10, PC/target width (= PC width = instruction ROM address width)
CW, 16, cycle counter width
P1_BASE, 0, start address of program 1 (ProgSel=0)
P2_BASE, 128, start address of program 2 (ProgSel=1)
P3_BASE, 256, start address of program 3 (ProgSel=2)
TIMEOUT, 4095, max RUN cycles before forced stop (must be < 2^CW)

Ports:
Clk  in  1  single clock, all state changes on posedge
Reset  in  1  synchronous, active-high; forces IDLE and clears all state
Req  in  1  start request, sampled in IDLE only
ProgSel  in  2  program select; 3 is invalid
Halt  in  1  decoded halt instruction at current PC
BrEn  in  1  decoded branch instruction at current PC
BrAbs  in  1  1 = absolute target, 0 = PC-relative
BrCond  in  1  1 = conditional on Flag, 0 = unconditional
Flag  in  1  condition flag from ALU
BrTarget  in  L  branch target / offset (two's complement when relative)
PcReset  out  1  PC reset control
PcStart  out  1  PC hold (1 = PC does not increment)
PcBranchAbs  out  1  PC absolute load
PcBranchRel  out  1  PC relative add
PcTarget  out  L  PC target value
Busy  out  1  program loading or running
Done  out  1  one-cycle completion pulse
Timeout  out  1  sticky watchdog flag
CycleCount  out  CW  RUN cycles of current/last program

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Registered state; PC control outputs are combinational from state + inputs.
- PcReset = Reset (combinational pass-through). The PC clears on the same edge as the sequencer.
- Reset values (registered state, on the cycle after Reset asserted):
  - state = IDLE; Busy = 0, Done = 0, Timeout = 0, CycleCount = 0
  - PcStart = 1; PcBranchAbs = 0, PcBranchRel = 0, PcTarget = 0
- Reset mid-LOAD or mid-RUN aborts immediately; no Done pulse.
- IDLE:
  - Outputs: PcStart = 1; branch outputs 0; PcTarget = 0.
  - Req & ProgSel != 3: latch ProgSel, go to LOAD.
  - Req & ProgSel == 3: ignored, stay IDLE.
  - Halt/BrEn are ignored.
- LOAD (exactly 1 cycle):
  - Outputs: PcBranchAbs = 1; PcTarget = base[latched sel]; PcStart = 0.
  - On exit: CycleCount <= 0, Timeout <= 0; next state RUN.
  - The PC holds the base address at the first RUN cycle.
- RUN, priority order:
  1. Halt: PcStart = 1, no branch outputs; next state DONE.
  2. Watchdog, when CycleCount == TIMEOUT: PcStart = 1; Timeout <= 1; next state DONE. Halt in the same cycle is still honoured as a halt, and Timeout is still set.
  3. Taken branch, where taken = BrEn & (~BrCond | Flag): PcBranchAbs = BrAbs, PcBranchRel = ~BrAbs, PcTarget = BrTarget.
  4. Otherwise: PcStart = 0, all branch outputs 0 (PC increments).
- CycleCount:
  - Increments by 1 on each RUN cycle that does not exit RUN.
  - Saturates at 2^CW-1.
  - Holds its value in DONE/IDLE until the next LOAD.
- Branch/halt decisions are same-cycle: the decision made in cycle n takes effect in the PC value of cycle n+1. Zero added latency.
- Relative arithmetic is done in the PC (L-bit wrap); the sequencer passes BrTarget unmodified.
- DONE (exactly 1 cycle):
  - Outputs: Done = 1, PcStart = 1; next state IDLE.
  - Req in DONE is ignored (it is not queued).
- Busy = (state == LOAD) | (state == RUN).
- Not-taken conditional branch (BrEn=1, BrCond=1, Flag=0): behaves as a plain increment.

Test Plan:
- Reset 2 cycles, then idle 3 cycles -> PcStart=1, Busy=0, Done=0, CycleCount=0, PC stays 0.
- Req with ProgSel=1 -> next cycle LOAD: PcBranchAbs=1, PcTarget=128; PC=128, 129, 130 on following cycles; Halt at PC=130 -> Done pulses exactly 1 cycle, CycleCount=2, Busy drops, PC holds 130.
- RUN with BrEn=1, BrCond=1, BrAbs=0, BrTarget=-3 (10'h3FD): with Flag=0 -> PC+1; with Flag=1 -> PC-3. Then BrAbs=1, BrCond=0, BrTarget=5 -> PC=5 next cycle.
- Req with ProgSel=3 -> stays IDLE, no LOAD, PcBranchAbs never asserted. Req asserted during DONE -> ignored, returns to IDLE.
- TIMEOUT overridden to 8, program never halts -> after 8 RUN cycles Timeout=1, Done pulses, CycleCount=8. Next accepted Req clears Timeout during LOAD.
- Reset asserted mid-RUN with BrEn=1 the same cycle -> PcReset=1, PC=0 next cycle, state IDLE, no Done pulse, CycleCount=0.
